// File: rtl/seg_scan_decoder.sv
// Passive snooper for a multiplexed, active-low 4-digit 7-segment bus.
// Recovers each digit's hex value plus valid / blank / stale status.
module seg_scan_decoder #(
    parameter int SETTLE  = 4,
    parameter int TIMEOUT = 65536
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  an,
    input  logic [6:0]  seg,
    output logic [15:0] digits,
    output logic [3:0]  valid,
    output logic [3:0]  blank,
    output logic        bad_pattern,
    output logic        err_sticky,
    output logic        frame_done
);
    localparam int CNT_W = $clog2(SETTLE + 1);
    localparam int AGE_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(SETTLE);
    localparam logic [AGE_W-1:0] AGE_MAX  = AGE_W'(TIMEOUT);
    localparam logic [AGE_W-1:0] AGE_LAST = AGE_W'(TIMEOUT - 1);
    localparam logic [6:0]       SEG_OFF  = 7'h7F;

    localparam logic [1:0] ST_WAIT    = 2'd0;
    localparam logic [1:0] ST_SETTLE  = 2'd1;
    localparam logic [1:0] ST_CAPTURE = 2'd2;
    localparam logic [1:0] ST_HOLD    = 2'd3;

    function automatic logic an_legal(input logic [3:0] a);
        logic ok;
        case (a)
            4'b1110, 4'b1101, 4'b1011, 4'b0111: ok = 1'b1;
            default:                            ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [1:0] an_index(input logic [3:0] a);
        logic [1:0] idx;
        case (a)
            4'b1101: idx = 2'd1;
            4'b1011: idx = 2'd2;
            4'b0111: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

    // Returns {hit, value}; hit=0 means the pattern is not a hex glyph.
    function automatic logic [4:0] glyph_decode(input logic [6:0] s);
        logic [4:0] r;
        case (s)
            7'h40:   r = 5'h10;
            7'h79:   r = 5'h11;
            7'h24:   r = 5'h12;
            7'h30:   r = 5'h13;
            7'h19:   r = 5'h14;
            7'h12:   r = 5'h15;
            7'h02:   r = 5'h16;
            7'h78:   r = 5'h17;
            7'h00:   r = 5'h18;
            7'h18:   r = 5'h19;
            7'h08:   r = 5'h1A;
            7'h03:   r = 5'h1B;
            7'h46:   r = 5'h1C;
            7'h21:   r = 5'h1D;
            7'h06:   r = 5'h1E;
            7'h0E:   r = 5'h1F;
            default: r = 5'h00;
        endcase
        return r;
    endfunction

    logic [3:0]       an_r;
    logic [6:0]       seg_r;
    logic [3:0]       an_lat_r;
    logic [6:0]       seg_lat_r;
    logic [1:0]       state_r;
    logic [1:0]       state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic             latch_s;
    logic             changed_s;
    logic [3:0]       seen_r;
    logic [AGE_W-1:0] age_r [4];
    logic             cap_s;
    logic [1:0]       cap_idx_s;
    logic [4:0]       glyph_s;
    logic             is_off_s;
    logic             is_bad_s;
    logic [3:0]       cap_mask_s;

    assign changed_s = (an_r != an_lat_r) || (seg_r != seg_lat_r);

    // Input sampling register and the pattern latch the FSM compares against.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            an_r      <= 4'hF;
            seg_r     <= SEG_OFF;
            an_lat_r  <= 4'hF;
            seg_lat_r <= SEG_OFF;
            state_r   <= ST_WAIT;
            cnt_r     <= '0;
        end else begin
            an_r    <= an;
            seg_r   <= seg;
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            if (latch_s) begin
                an_lat_r  <= an_r;
                seg_lat_r <= seg_r;
            end
        end
    end

    // Settle FSM: a capture needs SETTLE consecutive identical legal samples.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        latch_s     = 1'b0;
        case (state_r)
            ST_WAIT, ST_HOLD: begin
                if ((state_r == ST_WAIT) || changed_s) begin
                    if (an_legal(an_r)) begin
                        state_nxt_s = ST_SETTLE;
                        cnt_nxt_s   = CNT_W'(1);
                        latch_s     = 1'b1;
                    end else begin
                        state_nxt_s = ST_WAIT;
                    end
                end else begin
                    state_nxt_s = ST_HOLD;
                end
            end
            ST_SETTLE: begin
                if (changed_s) begin
                    latch_s   = 1'b1;
                    cnt_nxt_s = CNT_W'(1);
                    if (an_legal(an_r)) begin
                        state_nxt_s = ST_SETTLE;
                    end else begin
                        state_nxt_s = ST_WAIT;
                    end
                end else if (cnt_r >= CNT_LAST) begin
                    cnt_nxt_s   = CNT_FULL;
                    state_nxt_s = ST_CAPTURE;
                end else begin
                    cnt_nxt_s = cnt_r + CNT_W'(1);
                end
            end
            ST_CAPTURE: state_nxt_s = ST_HOLD;
            default:    state_nxt_s = ST_WAIT;
        endcase
    end

    // Classify the latched pattern while in CAPTURE.
    always_comb begin
        cap_s     = (state_r == ST_CAPTURE);
        cap_idx_s = an_index(an_lat_r);
        glyph_s   = glyph_decode(seg_lat_r);
        is_off_s  = (seg_lat_r == SEG_OFF);
        if (cap_s) begin
            cap_mask_s = 4'b0001 << cap_idx_s;
            is_bad_s   = !glyph_s[4] && !is_off_s;
        end else begin
            cap_mask_s = 4'b0000;
            is_bad_s   = 1'b0;
        end
    end

    // Per-digit status, ageing, error flags and frame tracking.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            digits      <= 16'h0000;
            valid       <= 4'b0000;
            blank       <= 4'b0000;
            bad_pattern <= 1'b0;
            err_sticky  <= 1'b0;
            frame_done  <= 1'b0;
            seen_r      <= 4'b0000;
            for (int k = 0; k < 4; k++) begin
                age_r[k] <= '0;
            end
        end else begin
            bad_pattern <= is_bad_s;
            err_sticky  <= err_sticky | is_bad_s;
            // A capture on the frame_done edge starts the next frame's mask.
            if (seen_r == 4'b1111) begin
                frame_done <= 1'b1;
                seen_r     <= cap_mask_s;
            end else begin
                frame_done <= 1'b0;
                seen_r     <= seen_r | cap_mask_s;
            end
            for (int k = 0; k < 4; k++) begin
                if (cap_mask_s[k]) begin
                    age_r[k] <= '0;
                    if (glyph_s[4]) begin
                        digits[4*k +: 4] <= glyph_s[3:0];
                        valid[k]         <= 1'b1;
                        blank[k]         <= 1'b0;
                    end else if (is_off_s) begin
                        valid[k] <= 1'b0;
                        blank[k] <= 1'b1;
                    end else begin
                        valid[k] <= 1'b0;
                        blank[k] <= 1'b0;
                    end
                end else if (age_r[k] != AGE_MAX) begin
                    age_r[k] <= age_r[k] + AGE_W'(1);
                    if (age_r[k] == AGE_LAST) begin
                        valid[k] <= 1'b0;
                        blank[k] <= 1'b0;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_seg_scan_decoder.sv
// Self-checking bench for seg_scan_decoder: directed scenarios plus randomized
// scan traffic compared against a run-length reference model.
module tb_seg_scan_decoder;
    localparam int SETTLE  = 4;
    localparam int TIMEOUT = 64;

    logic        clk;
    logic        reset;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic [15:0] digits;
    logic [3:0]  valid;
    logic [3:0]  blank;
    logic        bad_pattern;
    logic        err_sticky;
    logic        frame_done;

    int n_pass;
    int n_total;

    logic [6:0] glyph_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                   7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // Reference model state: digit contents, kind of last capture, edge of last capture.
    int          cyc;
    logic [3:0]  m_dig  [4];
    int          m_kind [4];
    int          m_last [4];
    logic [3:0]  m_seen;
    logic        m_err;
    logic        m_bad;
    logic        m_fd;
    logic [10:0] prev_smp;
    int          run_len;
    logic        due_v [4];
    logic [10:0] due_s [4];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    seg_scan_decoder #(.SETTLE(SETTLE), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .an(an), .seg(seg), .digits(digits), .valid(valid),
        .blank(blank), .bad_pattern(bad_pattern), .err_sticky(err_sticky),
        .frame_done(frame_done)
    );

    function automatic int zero_pos(input logic [3:0] a);
        int cnt = 0;
        int pos = -1;
        for (int i = 0; i < 4; i++) begin
            if (!a[i]) begin
                cnt++;
                pos = i;
            end
        end
        return (cnt == 1) ? pos : -1;
    endfunction

    function automatic int glyph_value(input logic [6:0] s);
        int v = -1;
        for (int i = 0; i < 16; i++) begin
            if (glyph_tab[i] == s) v = i;
        end
        return v;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin
            m_dig[k] = 4'h0; m_kind[k] = 0; m_last[k] = 0; due_v[k] = 1'b0; due_s[k] = 11'h0;
        end
        m_seen = 4'h0; m_err = 1'b0; m_bad = 1'b0; m_fd = 1'b0;
        prev_smp = 11'h7FF; run_len = 0;
    endtask

    task automatic model_edge(input logic [3:0] a, input logic [6:0] s);
        int slot;
        int k;
        int g;
        cyc++;
        m_bad = 1'b0;
        m_fd  = 1'b0;
        if (m_seen == 4'hF) begin
            m_fd = 1'b1;
            m_seen = 4'h0;
        end
        slot = cyc % 4;
        if (due_v[slot]) begin
            due_v[slot] = 1'b0;
            k = zero_pos(due_s[slot][10:7]);
            g = glyph_value(due_s[slot][6:0]);
            m_seen[k] = 1'b1;
            m_last[k] = cyc;
            if (g >= 0) begin
                m_dig[k] = 4'(g); m_kind[k] = 1;
            end else if (due_s[slot][6:0] == 7'h7F) begin
                m_kind[k] = 2;
            end else begin
                m_kind[k] = 3; m_bad = 1'b1; m_err = 1'b1;
            end
        end
        if ({a, s} == prev_smp) run_len++;
        else begin
            prev_smp = {a, s};
            run_len = 1;
        end
        // SETTLE identical legal samples -> outputs change two edges later.
        if (run_len == SETTLE && zero_pos(a) >= 0) begin
            due_v[(cyc + 2) % 4] = 1'b1;
            due_s[(cyc + 2) % 4] = {a, s};
        end
    endtask

    function automatic logic [26:0] model_out();
        logic [3:0] v;
        logic [3:0] b;
        for (int k = 0; k < 4; k++) begin
            v[k] = (m_kind[k] == 1) && (cyc - m_last[k] < TIMEOUT);
            b[k] = (m_kind[k] == 2) && (cyc - m_last[k] < TIMEOUT);
        end
        return {m_dig[3], m_dig[2], m_dig[1], m_dig[0], v, b, m_bad, m_err, m_fd};
    endfunction

    task automatic step(input logic [3:0] a, input logic [6:0] s);
        @(negedge clk);
        an = a;
        seg = s;
        @(posedge clk);
        model_edge(a, s);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; an = 4'hF; seg = 7'h7F; cyc = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        n_total++;
        if ({digits, valid, blank, bad_pattern, err_sticky, frame_done} !== 27'd0)
            $display("FAIL reset: outputs %h required 0",
                     {digits, valid, blank, bad_pattern, err_sticky, frame_done});
        else n_pass++;
        reset = 1'b0;
    endtask

    task automatic test_single_digit();
        logic [19:0] exp;
        for (int i = 1; i <= 10; i++) begin
            step(4'b1110, 7'h30);
            exp = (i >= SETTLE + 2) ? {4'b0001, 16'h0003} : 20'h0;
            n_total++;
            if ({valid, digits} !== exp)
                $display("FAIL single_digit cyc %0d: valid/digits %h required %h", i, {valid, digits}, exp);
            else n_pass++;
            n_total++;
            if (bad_pattern !== 1'b0) $display("FAIL single_digit_bad cyc %0d: got %b required 0", i, bad_pattern);
            else n_pass++;
        end
    endtask

    task automatic test_scan();
        logic [3:0] an_seq [4];
        logic [6:0] seg_seq [4];
        int fd_count;
        int fd_at;
        an_seq[0] = 4'b1110; an_seq[1] = 4'b1101; an_seq[2] = 4'b1011; an_seq[3] = 4'b0111;
        seg_seq[0] = 7'h12; seg_seq[1] = 7'h18; seg_seq[2] = 7'h46; seg_seq[3] = 7'h0E;
        fd_count = 0;
        fd_at = -1;
        for (int d = 0; d < 4; d++) begin
            for (int i = 1; i <= 8; i++) begin
                step(an_seq[d], seg_seq[d]);
                if (frame_done === 1'b1) begin
                    fd_count++;
                    fd_at = 8 * d + i;
                end
            end
        end
        n_total++;
        if (digits !== 16'hFC95) $display("FAIL scan_digits: got %h required fc95", digits);
        else n_pass++;
        n_total++;
        if (valid !== 4'b1111) $display("FAIL scan_valid: got %b required 1111", valid);
        else n_pass++;
        n_total++;
        if (fd_count !== 1 || fd_at !== 31)
            $display("FAIL scan_frame_done: %0d pulses at cyc %0d, required 1 at cyc 31", fd_count, fd_at);
        else n_pass++;
    endtask

    task automatic test_glitch();
        for (int i = 1; i <= 9; i++) begin
            step(4'b1101, (i <= 3) ? 7'h24 : 7'h30);
            n_total++;
            if (digits[7:4] === 4'h2) $display("FAIL glitch_seen cyc %0d: digit1 got 2 required not 2", i);
            else n_pass++;
        end
        n_total++;
        if (digits[7:4] !== 4'h3) $display("FAIL glitch_final: digit1 got %h required 3", digits[7:4]);
        else n_pass++;
    endtask

    task automatic test_blank_bad();
        int bad_count;
        repeat (7) step(4'b1011, 7'h7F);
        n_total++;
        if (blank !== 4'b0100 || valid[2] !== 1'b0)
            $display("FAIL blank: blank %b valid %b required blank 0100 valid[2] 0", blank, valid);
        else n_pass++;
        bad_count = 0;
        for (int i = 0; i < 12; i++) begin
            step(4'b1011, 7'h55);
            if (bad_pattern === 1'b1) bad_count++;
        end
        n_total++;
        if (bad_count !== 1) $display("FAIL bad_pulse: got %0d pulses required 1", bad_count);
        else n_pass++;
        n_total++;
        if (err_sticky !== 1'b1 || digits[11:8] !== 4'hC || blank[2] !== 1'b0)
            $display("FAIL bad_state: err %b digit2 %h blank %b required err 1 digit2 c blank[2] 0",
                     err_sticky, digits[11:8], blank);
        else n_pass++;
    endtask

    task automatic test_timeout();
        logic [3:0] exp_v;
        for (int d = 0; d < 4; d++) begin
            repeat (8) step(~(4'b0001 << d), glyph_tab[d + 1]);
        end
        for (int t = 33; t <= 132; t++) begin
            step(4'b1100, 7'($urandom));
            for (int k = 0; k < 4; k++) exp_v[k] = (t - (8 * k + 6)) < TIMEOUT;
            n_total++;
            if (valid !== exp_v || blank !== 4'b0000)
                $display("FAIL timeout cyc %0d: valid %b blank %b required valid %b blank 0000",
                         t, valid, blank, exp_v);
            else n_pass++;
        end
        n_total++;
        if (digits !== 16'h4321 || err_sticky !== 1'b1)
            $display("FAIL timeout_keep: digits %h err %b required 4321 err 1", digits, err_sticky);
        else n_pass++;
    endtask

    task automatic test_reset_mid_settle();
        logic [19:0] exp;
        repeat (4) step(4'b1110, 7'h79);
        #2 reset = 1'b1;
        #1;
        n_total++;
        if ({digits, valid, blank, bad_pattern, err_sticky, frame_done} !== 27'd0)
            $display("FAIL reset_async: outputs %h required 0",
                     {digits, valid, blank, bad_pattern, err_sticky, frame_done});
        else n_pass++;
        model_reset();
        @(posedge clk);
        #1 reset = 1'b0;
        for (int i = 1; i <= SETTLE + 2; i++) begin
            step(4'b1110, 7'h79);
            exp = (i == SETTLE + 2) ? {4'b0001, 16'h0001} : 20'h0;
            n_total++;
            if ({valid, digits} !== exp)
                $display("FAIL reset_resettle cyc %0d: valid/digits %h required %h", i, {valid, digits}, exp);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        logic [3:0]  a;
        logic [6:0]  s;
        logic [10:0] prev;
        logic [26:0] exp;
        int len;
        prev = {an, seg};
        for (int n = 0; n < 250; n++) begin
            do begin
                case ($urandom_range(0, 9))
                    0:       a = 4'b1111;
                    1:       a = 4'($urandom);
                    default: a = ~(4'b0001 << $urandom_range(0, 3));
                endcase
                case ($urandom_range(0, 9))
                    0:       s = 7'h7F;
                    1:       s = 7'($urandom);
                    default: s = glyph_tab[$urandom_range(0, 15)];
                endcase
            end while ({a, s} == prev);
            prev = {a, s};
            if (zero_pos(a) < 0 && $urandom_range(0, 7) == 0) len = $urandom_range(60, 80);
            else len = $urandom_range(1, 10);
            // A run of exactly SETTLE overlaps the capture cycle; keep runs clear of it.
            if (len == SETTLE) len = SETTLE + 1;
            for (int i = 0; i < len; i++) begin
                step(a, s);
                exp = model_out();
                n_total++;
                if ({digits, valid, blank, bad_pattern, err_sticky, frame_done} !== exp)
                    $display("FAIL random cyc %0d: outputs %h required %h", cyc,
                             {digits, valid, blank, bad_pattern, err_sticky, frame_done}, exp);
                else n_pass++;
            end
        end
    endtask

    initial begin
        n_pass = 0;
        n_total = 0;
        test_reset();
        test_single_digit();
        test_scan();
        test_glitch();
        test_blank_bad();
        test_timeout();
        test_reset_mid_settle();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
